grf_wb_arbiter: RTL and testbench

- Shares the single GRF write port (we/WA/WD/WPC) between two writeback requesters.
  - Source 0: main pipeline writeback (ALU/load).
  - Source 1: long-latency unit (mult/div result, late load).
- Each source has a small FIFO. A round-robin arbiter drains one entry per cycle into registered GRF write-port outputs.
- Also reports, for two read addresses, whether a write to that register is still pending. The decode stage uses this as a stall condition.

---
 rtl/grf_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
// Shares the single GRF write port between two writeback requesters. Each
// source feeds a small FIFO, and a round-robin arbiter drains one entry per
// cycle into registered write-port outputs. The block also reports whether
// a write to either of two read addresses is still queued or on the port.
//
// Optional feature: define GRF_WB_DISPLAY_EN to print every registered
// write to a non-zero register as "@<pc>: $<reg> <= <data>".
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous active-low reset
//   s0_valid/s0_ready   source 0 handshake (main pipeline writeback)
//   s0_addr/data/pc     source 0 destination register, data, PC
//   s1_*                same for source 1 (long-latency unit)
//   hold                freeze draining while the GRF port is borrowed
//   we/WA/WD/WPC        registered GRF write port (enable, addr, data, PC)
//   ra1/ra2             read addresses to check for pending writes
//   pend1/pend2         a write to ra1/ra2 is queued or on the port
//   busy                any FIFO non-empty or we high
//
// Handshake: a request transfers on a rising edge where sN_valid and
// sN_ready are both 1. sN_ready depends only on registered FIFO occupancy,
// never on the same-cycle pop, so a full FIFO stays not-ready even on a
// cycle where it drains.
module grf_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_addr,
    input  logic [DW-1:0] s0_data,
    input  logic [DW-1:0] s0_pc,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_addr,
    input  logic [DW-1:0] s1_data,
    input  logic [DW-1:0] s1_pc,
    input  logic          hold,
    output logic          we,
    output logic [AW-1:0] WA,
    output logic [DW-1:0] WD,
    output logic [DW-1:0] WPC,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          pend1,
    output logic          pend2,
    output logic          busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 2 * DW;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    // Entry layout: {addr, data, pc}
    logic [EW-1:0] mem_q    [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW:0]   cnt_q    [2];

    // Source that won the most recent tie; 1 after reset so source 0 wins first.
    logic          last_q, last_d;
    logic          we_q;
    logic [AW-1:0] wa_q;
    logic [DW-1:0] wd_q, wpc_q;

    logic [1:0]    in_valid, full, nempty, push, grant;
    logic [AW-1:0] in_addr  [2];
    logic [EW-1:0] in_entry [2];
    logic [EW-1:0] pop_entry;
    logic          hit1, hit2;
    logic [PW-1:0] off;

    assign in_valid    = {s1_valid, s0_valid};
    assign in_addr[0]  = s0_addr;
    assign in_addr[1]  = s1_addr;
    assign in_entry[0] = {s0_addr, s0_data, s0_pc};
    assign in_entry[1] = {s1_addr, s1_data, s1_pc};

    always_comb begin
        full   = 2'b00;
        nempty = 2'b00;
        push   = 2'b00;
        for (int s = 0; s < 2; s++) begin
            full[s]   = (cnt_q[s] == FULL_CNT);
            nempty[s] = (cnt_q[s] != '0);
            // Writes to $0 complete the handshake but are dropped here.
            push[s]   = in_valid[s] && !full[s] && (in_addr[s] != '0);
        end
    end

    // Round-robin: only a tie consults and updates the pointer.
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (!hold) begin
            if (nempty[0] && nempty[1]) begin
                grant  = last_q ? 2'b01 : 2'b10;
                last_d = ~last_q;
            end else begin
                grant = nempty;
            end
        end
        pop_entry = grant[1] ? mem_q[1][rd_ptr_q[1]] : mem_q[0][rd_ptr_q[0]];
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        off  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rd_ptr_q[s];
                if ({1'b0, off} < cnt_q[s]) begin
                    if (mem_q[s][i][EW-1 -: AW] == ra1) hit1 = 1'b1;
                    if (mem_q[s][i][EW-1 -: AW] == ra2) hit2 = 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_entry[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            last_q <= 1'b1;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            wpc_q  <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s])  wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
                if (grant[s]) rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
                cnt_q[s] <= cnt_q[s] + {{PW{1'b0}}, push[s]} - {{PW{1'b0}}, grant[s]};
            end
            last_q <= last_d;
            we_q   <= |grant;
            if (|grant) {wa_q, wd_q, wpc_q} <= pop_entry;
        end
    end

`ifdef GRF_WB_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (we_q && (wa_q != '0)) $display("@%h: $%d <= %h", wpc_q, wa_q, wd_q);
    end
`endif

    assign s0_ready = !full[0];
    assign s1_ready = !full[1];
    assign we       = we_q;
    assign WA       = wa_q;
    assign WD       = wd_q;
    assign WPC      = wpc_q;
    assign pend1    = (ra1 != '0) && (hit1 || (we_q && (wa_q == ra1)));
    assign pend2    = (ra2 != '0) && (hit2 || (we_q && (wa_q == ra2)));
    assign busy     = nempty[0] | nempty[1] | we_q;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int EW    = AW + 2 * DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          s0_valid = 1'b0, s1_valid = 1'b0, hold = 1'b0;
    logic [AW-1:0] s0_addr = '0, s1_addr = '0, ra1 = '0, ra2 = '0;
    logic [DW-1:0] s0_data = '0, s0_pc = '0, s1_data = '0, s1_pc = '0;
    logic          s0_ready, s1_ready, we, pend1, pend2, busy;
    logic [AW-1:0] WA;
    logic [DW-1:0] WD, WPC;

    grf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data), .s0_pc(s0_pc),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data), .s1_pc(s1_pc),
        .hold(hold), .we(we), .WA(WA), .WD(WD), .WPC(WPC),
        .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Queues of {addr, data, pc}; the port is a plain record of the last pop.
    logic [EW-1:0] mq0[$];
    logic [EW-1:0] mq1[$];
    logic [EW-1:0] exp_q[$];
    logic          m_last = 1'b1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0, m_wpc = '0;

    task automatic model_edge();
        logic acc0, acc1, pop0, pop1;
        logic [EW-1:0] e;
        if (!reset) begin
            mq0.delete(); mq1.delete(); exp_q.delete();
            m_last = 1'b1; m_we = 1'b0; m_wa = '0; m_wd = '0; m_wpc = '0;
            return;
        end
        acc0 = s0_valid && (mq0.size() < DEPTH);
        acc1 = s1_valid && (mq1.size() < DEPTH);
        pop0 = 1'b0; pop1 = 1'b0; e = '0;
        if (!hold) begin
            if (mq0.size() > 0 && mq1.size() > 0) begin
                if (m_last) pop0 = 1'b1; else pop1 = 1'b1;
                m_last = pop1;
            end else if (mq0.size() > 0) pop0 = 1'b1;
            else if (mq1.size() > 0) pop1 = 1'b1;
        end
        if (pop0) e = mq0.pop_front();
        if (pop1) e = mq1.pop_front();
        m_we = pop0 | pop1;
        if (m_we) begin
            {m_wa, m_wd, m_wpc} = e;
            exp_q.push_back(e);
        end
        if (acc0 && s0_addr != 0) mq0.push_back({s0_addr, s0_data, s0_pc});
        if (acc1 && s1_addr != 0) mq1.push_back({s1_addr, s1_data, s1_pc});
    endtask

    function automatic logic m_pend(logic [AW-1:0] ra);
        if (ra == 0) return 1'b0;
        foreach (mq0[i]) if (mq0[i][EW-1 -: AW] == ra) return 1'b1;
        foreach (mq1[i]) if (mq1[i][EW-1 -: AW] == ra) return 1'b1;
        return m_we && (m_wa == ra);
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0; s1_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; idle_inputs(); hold = 1'b0; ra1 = '0; ra2 = '0;
        tick(); tick();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", we); end
        checks++; if ({WA, WD, WPC} !== '0) begin failures++; $display("FAIL reset_port got=%0h/%0h/%0h exp=0", WA, WD, WPC); end
        checks++; if ({s0_ready, s1_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", {s0_ready, s1_ready}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        s0_valid = 1'b1; s0_addr = 7; s0_data = 3; s0_pc = 32'h3000;
        tick();
        idle_inputs();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL basic_no_passthru got=%0h exp=0", we); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_q got=%0h exp=1", busy); end
        tick();
        checks++; if ({we, WA, WD, WPC} !== {1'b1, 5'd7, 32'd3, 32'h3000}) begin
            failures++; $display("FAIL basic_write got=%0h/%0h/%0h/%0h exp=1/7/3/3000", we, WA, WD, WPC); end
        tick();
        checks++; if ({we, busy} !== 2'b00) begin failures++; $display("FAIL basic_after got=%b exp=00", {we, busy}); end
        checks++; if (WA !== 5'd7) begin failures++; $display("FAIL basic_keep_wa got=%0h exp=7", WA); end
    endtask

    task automatic test_tie();
        s0_valid = 1'b1; s0_addr = 5; s0_data = 32'hA; s0_pc = 32'h3004;
        s1_valid = 1'b1; s1_addr = 6; s1_data = 32'hB; s1_pc = 32'h3008;
        tick();
        idle_inputs();
        tick();
        checks++; if ({we, WA, WD, WPC} !== {1'b1, 5'd5, 32'hA, 32'h3004}) begin
            failures++; $display("FAIL tie_first got=%0h/%0h/%0h/%0h exp=1/5/a/3004", we, WA, WD, WPC); end
        tick();
        checks++; if ({we, WA, WD, WPC} !== {1'b1, 5'd6, 32'hB, 32'h3008}) begin
            failures++; $display("FAIL tie_second got=%0h/%0h/%0h/%0h exp=1/6/b/3008", we, WA, WD, WPC); end
        tick();
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL tie_done got=%0h exp=0", we); end
    endtask

    task automatic test_fairness();
        int n_sent = 0;
        int n_port = 0;
        int s1_pos = -1;
        int next_s0 = 10;
        logic acc0;
        for (int c = 0; c < 12; c++) begin
            s0_valid = (n_sent < 4);
            s0_addr = AW'(10 + n_sent); s0_data = 32'(100 + n_sent); s0_pc = 32'h4000 + 32'(4 * n_sent);
            s1_valid = (c == 0); s1_addr = 20; s1_data = 32'h200; s1_pc = 32'h5000;
            acc0 = s0_valid && s0_ready;
            tick();
            if (acc0) n_sent++;
            if (we) begin
                if (WA == 20) s1_pos = n_port;
                else begin
                    checks++; if (WA !== AW'(next_s0)) begin failures++; $display("FAIL fair_s0_order got=%0d exp=%0d", WA, next_s0); end
                    next_s0++;
                end
                n_port++;
            end
        end
        idle_inputs();
        checks++; if (!(s1_pos == 0 || s1_pos == 1)) begin failures++; $display("FAIL fair_s1_wait got=%0d exp<=1", s1_pos); end
        checks++; if (n_port !== 5) begin failures++; $display("FAIL fair_count got=%0d exp=5", n_port); end
    endtask

    task automatic test_zero_filter();
        s0_valid = 1'b1; s0_addr = 0; s0_data = 32'hFF; s0_pc = 32'h3100; ra1 = 0;
        checks++; if (s0_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0h exp=1", s0_ready); end
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            checks++; if ({we, pend1, busy} !== 3'b000) begin failures++; $display("FAIL zero_quiet got=%b exp=000", {we, pend1, busy}); end
            tick();
        end
    endtask

    task automatic test_full();
        hold = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            s1_valid = 1'b1; s1_addr = AW'(a); s1_data = 32'(256 + a); s1_pc = 32'h6000 + 32'(a);
            checks++; if (s1_ready !== (a < 3)) begin failures++; $display("FAIL full_ready_%0d got=%0h exp=%0h", a, s1_ready, a < 3); end
            tick();
            checks++; if (we !== 1'b0) begin failures++; $display("FAIL full_hold_we got=%0h exp=0", we); end
        end
        idle_inputs(); hold = 1'b0;
        tick();
        checks++; if ({we, WA, WD} !== {1'b1, 5'd1, 32'd257}) begin failures++; $display("FAIL full_w1 got=%0h/%0h/%0h exp=1/1/101", we, WA, WD); end
        tick();
        checks++; if ({we, WA, WD, s1_ready} !== {1'b1, 5'd2, 32'd258, 1'b1}) begin
            failures++; $display("FAIL full_w2 got=%0h/%0h/%0h/%0h exp=1/2/102/1", we, WA, WD, s1_ready); end
        tick();
        checks++; if ({we, busy} !== 2'b00) begin failures++; $display("FAIL full_done got=%b exp=00", {we, busy}); end
    endtask

    task automatic test_pending();
        hold = 1'b1; ra1 = 9; ra2 = 8;
        s0_valid = 1'b1; s0_addr = 9; s0_data = 32'h99; s0_pc = 32'h7000;
        tick();
        idle_inputs();
        checks++; if ({pend1, pend2} !== 2'b10) begin failures++; $display("FAIL pend_queued got=%b exp=10", {pend1, pend2}); end
        tick();
        checks++; if ({we, pend1} !== 2'b01) begin failures++; $display("FAIL pend_held got=%b exp=01", {we, pend1}); end
        hold = 1'b0;
        tick();
        checks++; if ({we, WA, pend1} !== {1'b1, 5'd9, 1'b1}) begin failures++; $display("FAIL pend_port got=%0h/%0h/%0h exp=1/9/1", we, WA, pend1); end
        tick();
        checks++; if ({we, pend1, pend2} !== 3'b000) begin failures++; $display("FAIL pend_drop got=%b exp=000", {we, pend1, pend2}); end
        ra1 = 0; ra2 = 0;
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s0_valid = 1'b1; s0_addr = AW'(1 + k); s0_data = 32'(k); s0_pc = 32'h8000;
            s1_valid = 1'b1; s1_addr = AW'(3 + k); s1_data = 32'(k); s1_pc = 32'h9000;
            tick();
        end
        idle_inputs();
        checks++; if ({s0_ready, s1_ready} !== 2'b00) begin failures++; $display("FAIL rmid_full got=%b exp=00", {s0_ready, s1_ready}); end
        reset = 1'b0;
        tick();
        reset = 1'b1; hold = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({we, s0_ready, s1_ready, busy} !== 4'b0110) begin
                failures++; $display("FAIL rmid_quiet got=%b exp=0110", {we, s0_ready, s1_ready, busy}); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] exp_e;
        exp_q.delete();
        for (int c = 0; c < 500; c++) begin
            reset    = ($urandom_range(0, 99) != 0);
            hold     = ($urandom_range(0, 7) == 0);
            s0_valid = ($urandom_range(0, 2) != 0);
            s0_addr  = AW'($urandom_range(0, 7)); s0_data = $urandom; s0_pc = $urandom;
            s1_valid = ($urandom_range(0, 2) != 0);
            s1_addr  = AW'($urandom_range(0, 7)); s1_data = $urandom; s1_pc = $urandom;
            ra1      = AW'($urandom_range(0, 7));
            ra2      = AW'($urandom_range(0, 7));
            tick();
            checks++; if (we !== m_we) begin failures++; $display("FAIL rnd_we cyc=%0d got=%0h exp=%0h", c, we, m_we); end
            if (m_we && exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                checks++; if ({WA, WD, WPC} !== exp_e) begin failures++; $display("FAIL rnd_write cyc=%0d got=%0h exp=%0h", c, {WA, WD, WPC}, exp_e); end
            end
            checks++; if ({WA, WD, WPC} !== {m_wa, m_wd, m_wpc}) begin
                failures++; $display("FAIL rnd_port cyc=%0d got=%0h exp=%0h", c, {WA, WD, WPC}, {m_wa, m_wd, m_wpc}); end
            checks++; if ({s0_ready, s1_ready} !== {mq0.size() < DEPTH, mq1.size() < DEPTH}) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, {s0_ready, s1_ready}, {mq0.size() < DEPTH, mq1.size() < DEPTH}); end
            checks++; if ({pend1, pend2} !== {m_pend(ra1), m_pend(ra2)}) begin
                failures++; $display("FAIL rnd_pend cyc=%0d got=%b exp=%b", c, {pend1, pend2}, {m_pend(ra1), m_pend(ra2)}); end
            checks++; if (busy !== (mq0.size() > 0 || mq1.size() > 0 || m_we)) begin
                failures++; $display("FAIL rnd_busy cyc=%0d got=%0h", c, busy); end
        end
        reset = 1'b1; hold = 1'b0; idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_fairness();
        test_zero_filter();
        test_full();
        test_pending();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
